// File: rtl/tt_um_seq_div.sv
// Multi-cycle 4-bit unsigned restoring divider, one quotient bit per clock.
// Operands on ui_in, start on uio_in[0], result on uo_out, status on uio_out.
module tt_um_seq_div (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t     r_state, w_stateNext;
    logic       r_startQ;
    logic [3:0] r_aReg, w_aNext;
    logic [3:0] r_bReg, w_bNext;
    logic [4:0] r_rem, w_remNext;
    logic [3:0] r_quo, w_quoNext;
    logic [1:0] r_cnt, w_cntNext;
    logic [3:0] r_q, w_qNext;
    logic [3:0] r_r, w_rNext;
    logic       r_busy, w_busyNext;
    logic       r_done, w_doneNext;
    logic       r_dbz, w_dbzNext;

    logic [3:0] w_opA, w_opB;
    logic       w_go;
    logic [4:0] w_trial;
    logic       w_unused;

    assign w_opA    = ui_in[3:0];
    assign w_opB    = ui_in[7:4];
    assign w_go     = uio_in[0] & ~r_startQ;
    assign w_unused = &{1'b0, ena, uio_in[7:1]};

    // Next-state and datapath: a rising start edge launches from IDLE or DONE,
    // RUN shifts one dividend bit into the partial remainder per clock.
    always_comb begin
        w_stateNext = r_state;
        w_aNext     = r_aReg;
        w_bNext     = r_bReg;
        w_remNext   = r_rem;
        w_quoNext   = r_quo;
        w_cntNext   = r_cnt;
        w_qNext     = r_q;
        w_rNext     = r_r;
        w_busyNext  = r_busy;
        w_doneNext  = r_done;
        w_dbzNext   = r_dbz;
        w_trial     = {r_rem[3:0], r_quo[3]};

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_go) begin
                    w_aNext = w_opA;
                    w_bNext = w_opB;
                    if (w_opB == 4'd0) begin
                        w_stateNext = S_DONE;
                        w_qNext     = 4'hF;
                        w_rNext     = w_opA;
                        w_dbzNext   = 1'b1;
                        w_doneNext  = 1'b1;
                        w_busyNext  = 1'b0;
                    end else begin
                        w_stateNext = S_RUN;
                        w_remNext   = 5'd0;
                        w_quoNext   = w_opA;
                        w_cntNext   = 2'd0;
                        w_busyNext  = 1'b1;
                        w_doneNext  = 1'b0;
                        w_dbzNext   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (w_trial >= {1'b0, r_bReg}) begin
                    w_remNext = w_trial - {1'b0, r_bReg};
                    w_quoNext = {r_quo[2:0], 1'b1};
                end else begin
                    w_remNext = w_trial;
                    w_quoNext = {r_quo[2:0], 1'b0};
                end
                w_cntNext = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_qNext     = w_quoNext;
                    w_rNext     = w_remNext[3:0];
                    w_busyNext  = 1'b0;
                    w_doneNext  = 1'b1;
                    w_stateNext = S_DONE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_startQ <= 1'b0;
            r_aReg   <= 4'd0;
            r_bReg   <= 4'd0;
            r_rem    <= 5'd0;
            r_quo    <= 4'd0;
            r_cnt    <= 2'd0;
            r_q      <= 4'd0;
            r_r      <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_startQ <= uio_in[0];
            r_aReg   <= w_aNext;
            r_bReg   <= w_bNext;
            r_rem    <= w_remNext;
            r_quo    <= w_quoNext;
            r_cnt    <= w_cntNext;
            r_q      <= w_qNext;
            r_r      <= w_rNext;
            r_busy   <= w_busyNext;
            r_done   <= w_doneNext;
            r_dbz    <= w_dbzNext;
        end
    end

    assign uo_out  = {r_r, r_q};
    assign uio_out = {4'b0000, r_dbz, r_done, r_busy, 1'b0};
    assign uio_oe  = 8'b0000_1110;

endmodule

// File: tb/tb_tt_um_seq_div.sv
// Directed self-checking bench for the sequential 4-bit divider tile.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tt_um_seq_div;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    int checks = 0;
    int errors = 0;

    tt_um_seq_div dut (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena)
    );

    always #5 clk = ~clk;

    // Launches one operation with a single-cycle start pulse and waits until
    // the normal completion point (fifth falling edge after the start is set).
    task automatic runOp(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        ui_in  = {b, a};
        uio_in = 8'h01;
        @(negedge clk);
        uio_in = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_uo_out: got %h expected 00", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_uio_out: got %h expected 00", uio_out);
        end
        checks++;
        if (uio_oe !== 8'h0E) begin
            errors++;
            $display("[TB] FAIL reset_uio_oe: got %h expected 0E", uio_oe);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        @(negedge clk);
        ui_in  = 8'h3D;
        uio_in = 8'h01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            uio_in = 8'h00;
            checks++;
            if (uio_out !== 8'h02) begin
                errors++;
                $display("[TB] FAIL basic_busy[%0d]: got %h expected 02", i, uio_out);
            end
            checks++;
            if (uo_out !== 8'h00) begin
                errors++;
                $display("[TB] FAIL basic_hold_prev[%0d]: got %h expected 00", i, uo_out);
            end
        end
        @(negedge clk);
        checks++;
        if (uio_out !== 8'h04) begin
            errors++;
            $display("[TB] FAIL basic_done: got %h expected 04", uio_out);
        end
        checks++;
        if (uo_out !== 8'h14) begin
            errors++;
            $display("[TB] FAIL basic_result: got %h expected 14", uo_out);
        end
    endtask

    task automatic test_back_to_back;
        runOp(4'd15, 4'd1);
        checks++;
        if (uo_out !== 8'h0F) begin
            errors++;
            $display("[TB] FAIL b2b_15_1: got %h expected 0F", uo_out);
        end
        runOp(4'd2, 4'd9);
        checks++;
        if (uo_out !== 8'h20) begin
            errors++;
            $display("[TB] FAIL b2b_2_9: got %h expected 20", uo_out);
        end
        checks++;
        if (uio_out !== 8'h04) begin
            errors++;
            $display("[TB] FAIL b2b_status: got %h expected 04", uio_out);
        end
    endtask

    task automatic test_div_by_zero;
        @(negedge clk);
        ui_in  = 8'h07;
        uio_in = 8'h01;
        @(negedge clk);
        uio_in = 8'h00;
        checks++;
        if (uio_out !== 8'h0C) begin
            errors++;
            $display("[TB] FAIL dbz_status: got %h expected 0C", uio_out);
        end
        checks++;
        if (uo_out !== 8'h7F) begin
            errors++;
            $display("[TB] FAIL dbz_result: got %h expected 7F", uo_out);
        end
        @(negedge clk);
        checks++;
        if (uio_out !== 8'h0C) begin
            errors++;
            $display("[TB] FAIL dbz_hold: got %h expected 0C", uio_out);
        end
    endtask

    task automatic test_start_held;
        @(negedge clk);
        ui_in  = 8'h29;
        uio_in = 8'h01;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 1) ui_in = 8'hFF;
            if (i >= 4) begin
                checks++;
                if ({uio_out, uo_out} !== 16'h0414) begin
                    errors++;
                    $display("[TB] FAIL held_start[%0d]: got %h expected 0414", i, {uio_out, uo_out});
                end
            end
        end
        uio_in = 8'h00;
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        ui_in  = 8'h3D;
        uio_in = 8'h01;
        @(negedge clk);
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({uio_out, uo_out} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL abort_async: got %h expected 0000", {uio_out, uo_out});
        end
        @(negedge clk);
        rst = 1'b0;
        runOp(4'd6, 4'd3);
        checks++;
        if ({uio_out, uo_out} !== 16'h0402) begin
            errors++;
            $display("[TB] FAIL abort_rerun: got %h expected 0402", {uio_out, uo_out});
        end
    endtask

    task automatic test_sweep;
        logic [7:0] expOut;
        logic [7:0] expStat;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                runOp(4'(a), 4'(b));
                if (b == 0) begin
                    expOut  = {4'(a), 4'hF};
                    expStat = 8'h0C;
                end else begin
                    expOut  = {4'(a % b), 4'(a / b)};
                    expStat = 8'h04;
                end
                checks++;
                if (uo_out !== expOut) begin
                    errors++;
                    $display("[TB] FAIL sweep_a%0d_b%0d: got %h expected %h", a, b, uo_out, expOut);
                end
                checks++;
                if (uio_out !== expStat) begin
                    errors++;
                    $display("[TB] FAIL sweep_status_a%0d_b%0d: got %h expected %h", a, b, uio_out, expStat);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        test_reset;
        test_basic;
        test_back_to_back;
        test_div_by_zero;
        test_start_held;
        test_reset_abort;
        test_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
